xor_apuf_engine: RTL and testbench
==================================

// Module: xor_apuf_engine
// PURPOSE
//  Parametrised XOR arbiter-PUF evaluation engine: N_CHAINS arbiter chains of N_STAGES
//  mux4_to_2 switch stages, each ending in a D_Flip_Flop arbiter, plus a clocked controller.
//  Latches a challenge, then launches the race N_VOTES times.
//  Majority-votes each chain's arbiter result (temporal majority voting) and XORs the voted bits.
//  Sits between the challenge source (test FSM / host) and the response collector.
// PARAMETERS
//  N_STAGES    22  switch stages per chain; challenge bits per chain
//  N_CHAINS    4   parallel chains XORed into response (1 = plain arbiter PUF)
//  SETTLE_CYC  8   clk cycles held in each of ARM and FIRE; >=1
//  N_VOTES     5   evaluations per request; odd, >=1
// PORTS
//  clk        in   1                   single clock, all control logic on rising edge
//  rst        in   1                   synchronous, active-high reset
//  start      in   1                   request; accepted only in IDLE
//  challenge  in   N_CHAINS*N_STAGES   chain c uses bits [c*N_STAGES +: N_STAGES]
//  busy       out  1                   high from accept cycle+1 through DONE
//  done       out  1                   1-cycle pulse, response/chain_resp valid
//  response   out  1                   XOR of chain_resp
//  chain_resp out  N_CHAINS            per-chain majority-voted bit
// BEHAVIOUR
//  - Reset (rst high at posedge): state=IDLE, busy=0, done=0, response=0, chain_resp=0,
//    vote/settle counters=0, race inputs X=Y=0, challenge register=0. Mid-operation reset
//    aborts the evaluation immediately; no done pulse is produced for the aborted request.
//  - start accepted in IDLE only; the challenge is registered on the accept edge and
//    held stable until DONE. start in any other state, including DONE, is ignored.
//  - FSM: IDLE -> ARM -> FIRE -> SYNC -> SAMPLE -> (ARM if votes_done<N_VOTES else DONE)
//    -> IDLE.
//    ARM:    X=Y=0 for SETTLE_CYC cycles (chains discharge).
//    FIRE:   X=Y=1, both asserted from the same flop, for SETTLE_CYC cycles.
//    SYNC:   2 cycles; each arbiter Q passes through a 2-flop synchroniser into clk.
//    SAMPLE: 1 cycle; ones_cnt[c] += synced Q[c]; votes_done++.
//    DONE:   1 cycle; done=1; outputs updated at the DONE entry edge.
//  - Latency: done high exactly 1 + N_VOTES*(2*SETTLE_CYC+3) cycles after the accept edge.
//    Defaults give 96 cycles.
//  - Arithmetic: ones_cnt width = $clog2(N_VOTES+1), unsigned, cleared on accept.
//    chain_resp[c] = (ones_cnt[c] > N_VOTES/2). response = ^chain_resp.
//  - response and chain_resp hold their last values until the next DONE or reset.
//  - Arbiter flops have no reset; their Q is only consumed in SAMPLE, after settling.
//  - Chain hierarchy (switch cells, arbiter) carries dont_touch; the controller does not.
// CONFIGURATION
//  STABILITY_FLAG_EN defined: adds output `unstable [N_CHAINS-1:0]`, reset 0.
//    Bit c=1 when ones_cnt[c] is neither 0 nor N_VOTES (non-unanimous vote).
//    Updated together with chain_resp at DONE and held until next DONE or reset.
//  STABILITY_FLAG_EN undefined: the port is not present and no comparators are built.
// TESTING
//  (Bench forces each chain's synchroniser input; delay-based racing is not simulated.)
//  1. Reset, defaults; force Q=1 on all chains; pulse start
//     -> done exactly 96 cycles later; chain_resp=4'b1111, response=0.
//  2. Force Q=1 on chain 0 only -> chain_resp=4'b0001, response=1,
//     busy high from cycle+1 through the DONE cycle.
//  3. Chain 2 toggles per vote 1,0,1,0,1 (3 ones) -> chain_resp[2]=1.
//     With STABILITY_FLAG_EN: unstable=4'b0100.
//  4. start re-pulsed while busy and again in the DONE cycle
//     -> ignored; exactly one done pulse; challenge register unchanged.
//  5. rst asserted at cycle 40 of evaluation -> next cycle IDLE, busy=0, outputs 0,
//     no done pulse. A new start then completes normally in 96 cycles.
//  6. N_CHAINS=1, N_VOTES=1, SETTLE_CYC=1 -> done 6 cycles after accept;
//     response equals the single forced Q.

Source files
------------

// File: rtl/xor_apuf_engine_if.sv
// Host-side handshake for the XOR arbiter-PUF engine.
// The optional `unstable` flags exist only when STABILITY_FLAG_EN is defined.
interface xor_apuf_engine_if #(
  parameter int N_CHAINS = 4,
  parameter int N_STAGES = 22
);
  logic                         start;
  logic [N_CHAINS*N_STAGES-1:0] challenge;
  logic                         busy;
  logic                         done;
  logic                         response;
  logic [N_CHAINS-1:0]          chain_resp;
`ifdef STABILITY_FLAG_EN
  logic [N_CHAINS-1:0]          unstable;

  modport master (output start, challenge,
                  input  busy, done, response, chain_resp, unstable);
  modport slave  (input  start, challenge,
                  output busy, done, response, chain_resp, unstable);
`else
  modport master (output start, challenge,
                  input  busy, done, response, chain_resp);
  modport slave  (input  start, challenge,
                  output busy, done, response, chain_resp);
`endif
endinterface

// File: rtl/xor_apuf_engine.sv
// XOR arbiter-PUF evaluation engine: N_CHAINS switch chains raced N_VOTES times,
// per-chain temporal majority vote, voted bits XORed into one response bit.
// Optional feature macro: STABILITY_FLAG_EN (adds per-chain non-unanimous flags).

// One switch stage: straight when sel=0, crossed when sel=1.
(* dont_touch = "true" *)
module mux4_to_2 (
  input  logic in_top,
  input  logic in_bot,
  input  logic sel,
  output logic out_top,
  output logic out_bot
);
  assign out_top = sel ? in_bot : in_top;
  assign out_bot = sel ? in_top : in_bot;
endmodule

// Arbiter: top path is data, bottom path is clock; no reset by design.
(* dont_touch = "true" *)
module d_flip_flop (
  input  logic d,
  input  logic clk,
  output logic q
);
  logic q_q;
  // Capture which edge won the race
  always_ff @(posedge clk) q_q <= d;
  assign q = q_q;
endmodule

// One arbiter chain: N_STAGES switches followed by the arbiter flop.
(* dont_touch = "true" *)
module xor_apuf_chain #(
  parameter int N_STAGES = 22
) (
  input  logic                x,
  input  logic                y,
  input  logic [N_STAGES-1:0] chal,
  output logic                q
);
  logic [N_STAGES:0] top, bot;

  assign top[0] = x;
  assign bot[0] = y;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    (* dont_touch = "true" *)
    mux4_to_2 u_sw (
      .in_top (top[i]),   .in_bot (bot[i]),   .sel (chal[i]),
      .out_top(top[i+1]), .out_bot(bot[i+1])
    );
  end

  (* dont_touch = "true" *)
  d_flip_flop u_arb (.d(top[N_STAGES]), .clk(bot[N_STAGES]), .q(q));
endmodule

module xor_apuf_engine #(
  parameter int N_STAGES   = 22,
  parameter int N_CHAINS   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int N_VOTES    = 5
) (
  input  logic              clk,
  input  logic              rst,
  xor_apuf_engine_if.slave  bus
);
  localparam int CW = $clog2(N_VOTES + 1);
  localparam int SW = $clog2(SETTLE_CYC + 2);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, SYNC, SAMPLE, DONE} state_e;

  state_e                       state_q, state_d;
  logic [SW-1:0]                settle_q, settle_d;
  logic [CW-1:0]                votes_q, votes_d;
  logic [CW-1:0]                ones_q [N_CHAINS];
  logic [CW-1:0]                ones_d [N_CHAINS];
  logic [CW-1:0]                ones_inc [N_CHAINS];
  logic                         race_q, race_d;
  logic [N_CHAINS*N_STAGES-1:0] chal_q, chal_d;
  logic                         busy_q, busy_d, done_q, done_d, resp_q, resp_d;
  logic [N_CHAINS-1:0]          chain_q, chain_d, chain_nxt;
  logic [N_CHAINS-1:0]          sync1_q, sync2_q;
  logic [N_CHAINS-1:0]          arb_raw, arb_q;
  logic [SW-1:0]                arm_last;
`ifdef STABILITY_FLAG_EN
  logic [N_CHAINS-1:0]          unstable_q, unstable_d, unstable_nxt;
`endif

  // Both race inputs come from the single race_q flop so X and Y launch together
  for (genvar c = 0; c < N_CHAINS; c++) begin : g_chain
    (* dont_touch = "true" *)
    xor_apuf_chain #(.N_STAGES(N_STAGES)) u_chain (
      .x   (race_q),
      .y   (race_q),
      .chal(chal_q[c*N_STAGES +: N_STAGES]),
      .q   (arb_raw[c])
    );
  end

  // Single net for all arbiter outputs feeding the synchronisers
  assign arb_q = arb_raw;

  // The accept cycle counts toward the first discharge window, so the first ARM
  // of a request is one cycle longer than the following ones.
  assign arm_last = (votes_q == '0) ? SW'(SETTLE_CYC) : SW'(SETTLE_CYC - 1);

  // Vote accumulation and majority/stability decisions for the SAMPLE cycle
  always_comb begin
    for (int c = 0; c < N_CHAINS; c++) begin
      ones_inc[c]  = ones_q[c] + CW'(sync2_q[c]);
      chain_nxt[c] = ones_inc[c] > CW'(N_VOTES / 2);
`ifdef STABILITY_FLAG_EN
      unstable_nxt[c] = (ones_inc[c] != '0) && (ones_inc[c] != CW'(N_VOTES));
`endif
    end
  end

  // Controller next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    votes_d  = votes_q;
    ones_d   = ones_q;
    race_d   = race_q;
    chal_d   = chal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    resp_d   = resp_q;
    chain_d  = chain_q;
`ifdef STABILITY_FLAG_EN
    unstable_d = unstable_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        chal_d   = bus.challenge;
        busy_d   = 1'b1;
        settle_d = '0;
        votes_d  = '0;
        ones_d   = '{default: '0};
        race_d   = 1'b0;
        state_d  = ARM;
      end
      ARM: begin
        if (settle_q == arm_last) begin
          settle_d = '0;
          race_d   = 1'b1;
          state_d  = FIRE;
        end else settle_d = settle_q + 1'b1;
      end
      FIRE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          settle_d = '0;
          race_d   = 1'b0;
          state_d  = SYNC;
        end else settle_d = settle_q + 1'b1;
      end
      SYNC: begin
        if (settle_q == SW'(1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else settle_d = settle_q + 1'b1;
      end
      SAMPLE: begin
        ones_d  = ones_inc;
        votes_d = votes_q + 1'b1;
        if (votes_q == CW'(N_VOTES - 1)) begin
          done_d  = 1'b1;
          chain_d = chain_nxt;
          resp_d  = ^chain_nxt;
`ifdef STABILITY_FLAG_EN
          unstable_d = unstable_nxt;
`endif
          state_d = DONE;
        end else state_d = ARM;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any evaluation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      votes_q  <= '0;
      ones_q   <= '{default: '0};
      race_q   <= 1'b0;
      chal_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resp_q   <= 1'b0;
      chain_q  <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
`ifdef STABILITY_FLAG_EN
      unstable_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      votes_q  <= votes_d;
      ones_q   <= ones_d;
      race_q   <= race_d;
      chal_q   <= chal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
      chain_q  <= chain_d;
      sync1_q  <= arb_q;
      sync2_q  <= sync1_q;
`ifdef STABILITY_FLAG_EN
      unstable_q <= unstable_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.response   = resp_q;
  assign bus.chain_resp = chain_q;
`ifdef STABILITY_FLAG_EN
  assign bus.unstable   = unstable_q;
`endif
endmodule

// File: tb/tb_xor_apuf_engine.sv
// Directed bench for xor_apuf_engine: arbiter outputs are forced, timing and
// vote results are checked against hand-computed values.
module tb_xor_apuf_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_apuf_engine_if #(.N_CHAINS(4), .N_STAGES(22)) ifc ();
  xor_apuf_engine_if #(.N_CHAINS(1), .N_STAGES(22)) ifc1 ();

  xor_apuf_engine u_dut (.clk(clk), .rst(rst), .bus(ifc));
  xor_apuf_engine #(.N_STAGES(22), .N_CHAINS(1), .SETTLE_CYC(1), .N_VOTES(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [3:0] q_drv  = 4'h0;
  logic       q_drv1 = 1'b0;
  logic [3:0] qv [5];

  localparam logic [87:0] CH_A = 88'hA5_1234_5678_9ABC_DEF0_1357;
  localparam logic [87:0] CH_B = 88'h3C_0F0F_F0F0_AAAA_5555_2468;

  always @(negedge clk) if (ifc.done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request on the default engine; vote k uses arbiter value qv[k]
  task automatic run_eval(input logic [87:0] chal, input bit repulse, output int lat);
    int  base;
    bit  busy_drop;
    base      = done_cnt;
    busy_drop = 1'b0;
    lat       = -1;
    q_drv     = qv[0];
    @(negedge clk);
    ifc.challenge = chal;
    ifc.start     = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk("busy_after_accept", ifc.busy, 1);
    for (int cnt = 1; cnt <= 200 && lat < 0; cnt++) begin
      @(posedge clk); #1;
      if (cnt >= 2 && (cnt - 2) % 19 == 0 && (cnt - 2) / 19 < 5) q_drv = qv[(cnt - 2) / 19];
      if (repulse && cnt == 30) begin ifc.start = 1'b1; ifc.challenge = ~chal; end
      if (repulse && cnt == 31) ifc.start = 1'b0;
      if (ifc.done) lat = cnt;
      else if (!ifc.busy) busy_drop = 1'b1;
    end
    chk("latency", lat, 96);
    chk("busy_hold", busy_drop, 0);
    chk("busy_in_done", ifc.busy, 1);
    if (repulse) ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk("busy_clear", ifc.busy, 0);
    chk("done_pulse_len", ifc.done, 0);
    if (repulse) begin
      repeat (120) @(posedge clk);
      #1;
      chk("single_done", done_cnt - base, 1);
      chk("chal_held", u_dut.chal_q, chal);
      chk("idle_after_repulse", ifc.busy, 0);
    end
  endtask

  initial begin
    int lat;
    force u_dut.arb_q  = q_drv;
    force u_dut1.arb_q = q_drv1;
    ifc.start  = 1'b0; ifc.challenge  = '0;
    ifc1.start = 1'b0; ifc1.challenge = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_resp", ifc.response, 0);
    chk("rst_chain", ifc.chain_resp, 0);
    chk("rst_chal", u_dut.chal_q, 0);
`ifdef STABILITY_FLAG_EN
    chk("rst_unstable", ifc.unstable, 0);
`endif

    // 1: all chains vote 1 -> even parity
    qv = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    run_eval(CH_A, 1'b0, lat);
    chk("t1_chain", ifc.chain_resp, 4'b1111);
    chk("t1_resp", ifc.response, 0);
`ifdef STABILITY_FLAG_EN
    chk("t1_unstable", ifc.unstable, 0);
`endif

    // 2: chain 0 only
    qv = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    run_eval(CH_B, 1'b0, lat);
    chk("t2_chain", ifc.chain_resp, 4'b0001);
    chk("t2_resp", ifc.response, 1);

    // 3: chain 2 toggles 1,0,1,0,1 -> 3 of 5 ones
    qv = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4};
    run_eval(CH_A, 1'b0, lat);
    chk("t3_chain", ifc.chain_resp, 4'b0100);
    chk("t3_resp", ifc.response, 1);
`ifdef STABILITY_FLAG_EN
    chk("t3_unstable", ifc.unstable, 4'b0100);
`endif

    // Minority case: chain 1 sees 2 of 5 ones -> votes 0
    qv = '{4'h2, 4'h0, 4'h2, 4'h0, 4'h0};
    run_eval(CH_B, 1'b0, lat);
    chk("minority_chain", ifc.chain_resp, 4'b0000);
    chk("minority_resp", ifc.response, 0);

    // 4: start while busy and in DONE is ignored
    qv = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
    run_eval(CH_B, 1'b1, lat);
    chk("t4_chain", ifc.chain_resp, 4'b0011);
    chk("t4_resp_held", ifc.response, 0);

    // Leave a nonzero response so the abort clear is visible
    qv = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    run_eval(CH_A, 1'b0, lat);
    chk("pre_abort_resp", ifc.response, 1);

    // 5: reset at cycle 40 aborts without a done pulse
    begin
      int base;
      base  = done_cnt;
      q_drv = 4'hF;
      @(negedge clk);
      ifc.challenge = CH_B;
      ifc.start     = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", ifc.busy, 0);
      chk("abort_done", ifc.done, 0);
      chk("abort_resp", ifc.response, 0);
      chk("abort_chain", ifc.chain_resp, 0);
      chk("abort_state", u_dut.state_q, 0);
      chk("abort_chal", u_dut.chal_q, 0);
      repeat (120) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - base, 0);
    end
    qv = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    run_eval(CH_A, 1'b0, lat);
    chk("post_abort_chain", ifc.chain_resp, 4'b1111);

    // 6: single chain, single vote, one-cycle settle -> 6-cycle latency
    for (int k = 0; k < 2; k++) begin
      int lat1;
      lat1   = -1;
      q_drv1 = (k == 0);
      @(negedge clk);
      ifc1.challenge = 22'h2AB3C1;
      ifc1.start     = 1'b1;
      @(posedge clk); #1;
      ifc1.start = 1'b0;
      for (int cnt = 1; cnt <= 50 && lat1 < 0; cnt++) begin
        @(posedge clk); #1;
        if (ifc1.done) lat1 = cnt;
      end
      chk("t6_latency", lat1, 6);
      chk("t6_resp", ifc1.response, (k == 0));
      chk("t6_chain", ifc1.chain_resp, (k == 0));
      @(posedge clk); #1;
      chk("t6_busy_clear", ifc1.busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
